// File: rtl/clk_div_pkg.sv
// Shared definitions for the integer clock divider and its ratio meter:
// counter width, measurement FSM encoding and the divider's duty-cycle rule.
package clk_div_pkg;

  localparam int unsigned CNT_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_HIGH = 2'd2,
    ST_LOW  = 2'd3
  } meas_state_e;

  // Odd ratios put the extra cycle in the low phase.
  function automatic logic [31:0] exp_high(input logic [31:0] n);
    return n >> 1;
  endfunction

  function automatic logic [31:0] exp_low(input logic [31:0] n);
    return n - (n >> 1);
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchronizer with asynchronous active-low reset, for single-bit
// signals crossing into the i_clk domain.
module bit_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Next values of the synchronizer chain.
  always_comb begin
    meta_d = i_d;
    sync_d = meta_q;
  end

  // Synchronizer flops.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign o_q = sync_q;

endmodule

// File: rtl/clk_ratio_meter.sv
// Measures high/low phase lengths of the divided clock in i_ref_clk cycles and
// checks them against the expected ratio; flags a stopped monitored clock.
module clk_ratio_meter
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 i_ref_clk,
  input  logic                 i_rst_n,
  input  logic                 i_mon_clk,
  input  logic                 i_meas_en,
  input  logic [CNT_WIDTH-1:0] i_exp_ratio,
  output logic [CNT_WIDTH-1:0] o_high_cnt,
  output logic [CNT_WIDTH-1:0] o_low_cnt,
  output logic [CNT_WIDTH:0]   o_ratio,
  output logic                 o_valid,
  output logic                 o_match,
  output logic                 o_timeout
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic                 mon_sync_s, rise_s, fall_s;
  logic                 hist_q, hist_d;
  meas_state_e          state_q, state_d;
  logic [CNT_WIDTH-1:0] hcnt_q, hcnt_d, lcnt_q, lcnt_d, idle_q, idle_d;
  logic [CNT_WIDTH-1:0] high_cnt_q, high_cnt_d, low_cnt_q, low_cnt_d;
  logic [CNT_WIDTH:0]   ratio_q, ratio_d;
  logic                 valid_q, valid_d, match_q, match_d, timeout_q, timeout_d;
  logic [CNT_WIDTH-1:0] exp_high_s, exp_low_s;

  bit_sync u_mon_sync (
    .i_clk   (i_ref_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_mon_clk),
    .o_q     (mon_sync_s)
  );

  // Edge detection against the history flop, plus the expected phase lengths.
  always_comb begin
    hist_d     = mon_sync_s;
    rise_s     = mon_sync_s & ~hist_q;
    fall_s     = ~mon_sync_s & hist_q;
    exp_high_s = CNT_WIDTH'(exp_high(32'(i_exp_ratio)));
    exp_low_s  = CNT_WIDTH'(exp_low(32'(i_exp_ratio)));
  end

  // State, counter and result registers.
  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hist_q     <= 1'b0;
      state_q    <= ST_IDLE;
      hcnt_q     <= CNT_ZERO;
      lcnt_q     <= CNT_ZERO;
      idle_q     <= CNT_ZERO;
      high_cnt_q <= CNT_ZERO;
      low_cnt_q  <= CNT_ZERO;
      ratio_q    <= {(CNT_WIDTH+1){1'b0}};
      valid_q    <= 1'b0;
      match_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      hist_q     <= hist_d;
      state_q    <= state_d;
      hcnt_q     <= hcnt_d;
      lcnt_q     <= lcnt_d;
      idle_q     <= idle_d;
      high_cnt_q <= high_cnt_d;
      low_cnt_q  <= low_cnt_d;
      ratio_q    <= ratio_d;
      valid_q    <= valid_d;
      match_q    <= match_d;
      timeout_q  <= timeout_d;
    end
  end

  // Next-state logic; a saturated phase counter without an edge restarts in SYNC.
  always_comb begin
    state_d = state_q;
    if (!i_meas_en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_SYNC;
        ST_SYNC: begin
          if (rise_s) state_d = ST_HIGH;
          else        state_d = ST_SYNC;
        end
        ST_HIGH: begin
          if (fall_s)               state_d = ST_LOW;
          else if (hcnt_q == CNT_MAX) state_d = ST_SYNC;
          else                      state_d = ST_HIGH;
        end
        ST_LOW: begin
          if (rise_s)               state_d = ST_HIGH;
          else if (lcnt_q == CNT_MAX) state_d = ST_SYNC;
          else                      state_d = ST_LOW;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Counters, publish and timeout; results hold between publishes.
  always_comb begin
    hcnt_d     = hcnt_q;
    lcnt_d     = lcnt_q;
    idle_d     = idle_q;
    high_cnt_d = high_cnt_q;
    low_cnt_d  = low_cnt_q;
    ratio_d    = ratio_q;
    match_d    = match_q;
    valid_d    = 1'b0;
    timeout_d  = timeout_q;
    if (!i_meas_en) begin
      hcnt_d    = CNT_ZERO;
      lcnt_d    = CNT_ZERO;
      idle_d    = CNT_ZERO;
      timeout_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          hcnt_d = CNT_ZERO;
          lcnt_d = CNT_ZERO;
          idle_d = CNT_ZERO;
        end
        ST_SYNC: begin
          if (rise_s) begin
            hcnt_d = CNT_ONE;
            idle_d = CNT_ZERO;
          end else if (fall_s) begin
            idle_d = CNT_ZERO;
          end else if (idle_q == CNT_MAX) begin
            timeout_d = 1'b1;
          end else begin
            idle_d = idle_q + CNT_ONE;
          end
        end
        ST_HIGH: begin
          if (fall_s) begin
            lcnt_d = CNT_ONE;
          end else if (hcnt_q == CNT_MAX) begin
            timeout_d = 1'b1;
            idle_d    = CNT_ZERO;
          end else begin
            hcnt_d = hcnt_q + CNT_ONE;
          end
        end
        ST_LOW: begin
          if (rise_s) begin
            high_cnt_d = hcnt_q;
            low_cnt_d  = lcnt_q;
            ratio_d    = {1'b0, hcnt_q} + {1'b0, lcnt_q};
            match_d    = (hcnt_q == exp_high_s) && (lcnt_q == exp_low_s);
            valid_d    = 1'b1;
            hcnt_d     = CNT_ONE;
          end else if (lcnt_q == CNT_MAX) begin
            timeout_d = 1'b1;
            idle_d    = CNT_ZERO;
          end else begin
            lcnt_d = lcnt_q + CNT_ONE;
          end
        end
        default: begin
          hcnt_d = CNT_ZERO;
          lcnt_d = CNT_ZERO;
          idle_d = CNT_ZERO;
        end
      endcase
    end
  end

  assign o_high_cnt = high_cnt_q;
  assign o_low_cnt  = low_cnt_q;
  assign o_ratio    = ratio_q;
  assign o_valid    = valid_q;
  assign o_match    = match_q;
  assign o_timeout  = timeout_q;

endmodule
